// File: rtl/spi_tx_pkg.sv
// Shared types and helpers for the SPI transmit path: FSM states, frame width
// helpers and the bit-order sort used for both data and CRC frames.
package spi_tx_pkg;

    localparam int unsigned MAX_DW = 64;
    localparam int unsigned MAX_LW = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CRC   = 2'd2
    } tx_state_e;

    function automatic int unsigned flen_to_width(input logic [MAX_LW-1:0] flen);
        return 32'(flen) + 32'd1;
    endfunction

    function automatic logic [MAX_DW-1:0] frame_mask(input logic [MAX_LW-1:0] flen);
        return ~({MAX_DW{1'b1}} << flen_to_width(flen));
    endfunction

    // The shifter always drives bit 0 first, so MSB-first frames are reversed
    // over bits 0..flen; bits above the frame are cleared.
    function automatic logic [MAX_DW-1:0] sort_word(input logic [MAX_DW-1:0] word,
                                                    input logic              lsbf,
                                                    input logic [MAX_LW-1:0] flen);
        logic [MAX_DW-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_DW; i++) begin
            if (i <= int'(flen)) begin
                r[i] = lsbf ? word[i] : word[int'(flen) - i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/spi_serial_crc.sv
// Width-selectable serial Galois CRC, one bit per enabled cycle, init to zero.
module spi_serial_crc
    import spi_tx_pkg::*;
#(
    parameter int unsigned DW = 32,
    parameter int unsigned LW = 5
) (
    input  logic          sclk_tx,
    input  logic          spi_tx_rst,
    input  logic          init,
    input  logic          en,
    input  logic          din,
    input  logic [DW-1:0] poly,
    input  logic [LW-1:0] flen,
    output logic [DW-1:0] crc,
    output logic [DW-1:0] crc_next
);

    logic [DW-1:0] crc_q;
    logic [DW-1:0] mask;
    logic          fb;

    always_comb begin
        mask     = DW'(frame_mask(MAX_LW'(flen)));
        fb       = crc_q[flen] ^ din;
        crc_next = crc_q;
        if (init) begin
            crc_next = '0;
        end else if (en) begin
            crc_next = ((crc_q << 1) ^ (poly & {DW{fb}})) & mask;
        end
    end

    always_ff @(posedge sclk_tx) begin
        if (spi_tx_rst) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_next;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/spi_txc_stream.sv
// SPI transmit shifter: TX FIFO, back-to-back variable-length frames, frame
// counting per transaction, optional trailing CRC frame and underrun zero-fill.
module spi_txc_stream
    import spi_tx_pkg::*;
#(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = 13
) (
    input  logic                  sclk_tx,
    input  logic                  spi_tx_rst,
    input  logic [DW-1:0]         wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [$clog2(DW)-1:0] frame_len,
    input  logic                  lsbf,
    input  logic                  crc_en,
    input  logic [DW-1:0]         crc_poly,
    input  logic [CW-1:0]         tnum_max,
    input  logic                  rxonly,
    output logic                  shift_out,
    output logic                  txe,
    output logic                  tx_start,
    output logic                  tx_busy,
    output logic                  tx_crc_phase,
    output logic                  tx_done,
    output logic                  underrun,
    output logic [DW-1:0]         crc_out
);

    localparam int unsigned LW = $clog2(DW);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [DW-1:0] fifo_mem [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   count_q;
    logic          rxonly_q, flush, push, pop;

    tx_state_e     state_q, state_d;
    logic [DW-1:0] sreg_q, sreg_d;
    logic [LW-1:0] bit_cnt_q, bit_cnt_d;
    logic [CW-1:0] frame_cnt_q, frame_cnt_d, cnt_inc;
    logic          tx_done_q, tx_done_d;
    logic          start, last, crc_init;

    logic [LW-1:0] flen_q, flen_sel;
    logic          lsbf_q, lsbf_sel, crc_en_q;
    logic [CW-1:0] tnum_q;
    logic [DW-1:0] poly_q;
    logic [DW-1:0] head_word, crc_word, crc_next;

    assign wr_ready = (count_q != FULL_CNT);
    assign txe      = (count_q == '0);
    // Flush once on entry to rxonly so the FIFO can be refilled while held.
    assign flush    = rxonly & ~rxonly_q;
    assign push     = wr_valid & wr_ready & ~flush;

    always_ff @(posedge sclk_tx) begin
        if (spi_tx_rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            rxonly_q <= 1'b0;
        end else begin
            rxonly_q <= rxonly;
            if (flush) begin
                wptr_q  <= '0;
                rptr_q  <= '0;
                count_q <= '0;
            end else begin
                if (push) wptr_q <= wptr_q + 1'b1;
                if (pop)  rptr_q <= rptr_q + 1'b1;
                count_q <= count_q + (AW + 1)'(push) - (AW + 1)'(pop);
            end
        end
    end

    always_ff @(posedge sclk_tx) begin
        if (push) fifo_mem[wptr_q] <= wr_data;
    end

    // Live configuration is used on the IDLE pop, shadows afterwards.
    always_comb begin
        flen_sel  = (state_q == IDLE) ? frame_len : flen_q;
        lsbf_sel  = (state_q == IDLE) ? lsbf : lsbf_q;
        head_word = DW'(sort_word(MAX_DW'(fifo_mem[rptr_q]), lsbf_sel, MAX_LW'(flen_sel)));
        crc_word  = DW'(sort_word(MAX_DW'(crc_next), lsbf_q, MAX_LW'(flen_q)));
    end

    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q >> 1;
        bit_cnt_d   = bit_cnt_q;
        frame_cnt_d = frame_cnt_q;
        tx_done_d   = 1'b0;
        pop         = 1'b0;
        start       = 1'b0;
        crc_init    = 1'b0;
        tx_start    = 1'b0;
        underrun    = 1'b0;
        last        = (bit_cnt_q == flen_q);
        cnt_inc     = frame_cnt_q + 1'b1;

        unique case (state_q)
            IDLE: begin
                sreg_d = sreg_q;
                if (!rxonly && !txe) begin
                    pop         = 1'b1;
                    start       = 1'b1;
                    crc_init    = 1'b1;
                    tx_start    = 1'b1;
                    sreg_d      = head_word;
                    bit_cnt_d   = '0;
                    frame_cnt_d = '0;
                    state_d     = SHIFT;
                end
            end
            SHIFT: begin
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (last) begin
                    bit_cnt_d   = '0;
                    frame_cnt_d = (tnum_q != '0 && cnt_inc >= tnum_q) ? tnum_q : cnt_inc;
                    if (tnum_q != '0 && cnt_inc == tnum_q) begin
                        if (crc_en_q) begin
                            sreg_d  = crc_word;
                            state_d = CRC;
                        end else begin
                            state_d   = IDLE;
                            tx_done_d = 1'b1;
                        end
                    end else if (!txe) begin
                        pop      = 1'b1;
                        tx_start = 1'b1;
                        sreg_d   = head_word;
                    end else if (tnum_q == '0) begin
                        state_d   = IDLE;
                        tx_done_d = 1'b1;
                    end else begin
                        sreg_d   = '0;
                        underrun = 1'b1;
                    end
                end
            end
            CRC: begin
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (last) begin
                    bit_cnt_d = '0;
                    state_d   = IDLE;
                    tx_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (rxonly) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            tx_done_d = 1'b0;
            pop       = 1'b0;
            start     = 1'b0;
            crc_init  = 1'b0;
            tx_start  = 1'b0;
            underrun  = 1'b0;
        end
    end

    always_ff @(posedge sclk_tx) begin
        if (spi_tx_rst) begin
            state_q     <= IDLE;
            sreg_q      <= '0;
            bit_cnt_q   <= '0;
            frame_cnt_q <= '0;
            tx_done_q   <= 1'b0;
            flen_q      <= '0;
            lsbf_q      <= 1'b0;
            crc_en_q    <= 1'b0;
            tnum_q      <= '0;
            poly_q      <= '0;
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            bit_cnt_q   <= bit_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            tx_done_q   <= tx_done_d;
            if (start) begin
                flen_q   <= frame_len;
                lsbf_q   <= lsbf;
                crc_en_q <= crc_en;
                tnum_q   <= tnum_max;
                poly_q   <= crc_poly;
            end
        end
    end

    spi_serial_crc #(
        .DW(DW),
        .LW(LW)
    ) u_crc (
        .sclk_tx   (sclk_tx),
        .spi_tx_rst(spi_tx_rst),
        .init      (crc_init),
        .en        (state_q == SHIFT),
        .din       (sreg_q[0]),
        .poly      (poly_q),
        .flen      (flen_q),
        .crc       (crc_out),
        .crc_next  (crc_next)
    );

    assign shift_out    = (state_q != IDLE) && sreg_q[0];
    assign tx_busy      = (state_q != IDLE);
    assign tx_crc_phase = (state_q == CRC);
    assign tx_done      = tx_done_q;

endmodule

// File: tb/tb_spi_txc_stream.sv
// Scenario bench for spi_txc_stream: expected serial bits queued at stimulus
// time, compared in order against the captured line.
module tb_spi_txc_stream;

    logic        clk;
    logic        spi_tx_rst;
    logic [31:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [4:0]  frame_len;
    logic        lsbf;
    logic        crc_en;
    logic [31:0] crc_poly;
    logic [12:0] tnum_max;
    logic        rxonly;
    logic        shift_out, txe, tx_start, tx_busy, tx_crc_phase, tx_done, underrun;
    logic [31:0] crc_out;

    int checks;
    int failures;

    bit   exp_q[$];
    logic obs_q[$];
    int   start_cyc[$];
    int   n_under, n_crc, first_busy, last_busy, done_cyc;
    bit   done_seen;

    spi_txc_stream #(
        .DW   (32),
        .DEPTH(4),
        .CW   (13)
    ) dut (
        .sclk_tx     (clk),
        .spi_tx_rst  (spi_tx_rst),
        .wr_data     (wr_data),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .frame_len   (frame_len),
        .lsbf        (lsbf),
        .crc_en      (crc_en),
        .crc_poly    (crc_poly),
        .tnum_max    (tnum_max),
        .rxonly      (rxonly),
        .shift_out   (shift_out),
        .txe         (txe),
        .tx_start    (tx_start),
        .tx_busy     (tx_busy),
        .tx_crc_phase(tx_crc_phase),
        .tx_done     (tx_done),
        .underrun    (underrun),
        .crc_out     (crc_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_cfg(input int fl, input bit lsb, input bit ce, input int tn,
                           input logic [31:0] poly);
        frame_len = 5'(fl);
        lsbf      = lsb;
        crc_en    = ce;
        tnum_max  = 13'(tn);
        crc_poly  = poly;
    endtask

    task automatic push_word(input logic [31:0] w);
        wr_data  = w;
        wr_valid = 1'b1;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic exp_word(input logic [31:0] w, input int fl, input bit lsb);
        for (int i = 0; i <= fl; i++) exp_q.push_back(lsb ? w[i] : w[fl - i]);
    endtask

    // Bit-serial reference: W = fl+1, init 0, MSB-first feedback.
    function automatic logic [31:0] model_crc(input int fl, input logic [31:0] poly);
        logic [31:0] crc, mask;
        logic        fb;
        crc  = '0;
        mask = (fl == 31) ? 32'hFFFF_FFFF : ((32'd1 << (fl + 1)) - 32'd1);
        foreach (exp_q[i]) begin
            fb  = crc[fl] ^ exp_q[i];
            crc = {crc[30:0], 1'b0};
            if (fb) crc = crc ^ poly;
            crc = crc & mask;
        end
        return crc;
    endfunction

    // Records the line until tx_done or the cycle budget runs out.
    task automatic collect(input int budget);
        obs_q.delete();
        start_cyc.delete();
        n_under    = 0;
        n_crc      = 0;
        first_busy = -1;
        last_busy  = -1;
        done_cyc   = -1;
        done_seen  = 1'b0;
        #1;
        for (int c = 0; c < budget; c++) begin
            if (tx_start) start_cyc.push_back(c);
            if (underrun) n_under++;
            if (tx_crc_phase) n_crc++;
            if (tx_busy) begin
                if (first_busy < 0) first_busy = c;
                last_busy = c;
                obs_q.push_back(shift_out);
            end
            if (tx_done) begin
                done_seen = 1'b1;
                done_cyc  = c;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        spi_tx_rst = 1'b1;
        step();
        step();
        checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL rst_wr_ready got=%b exp=1", wr_ready); end
        checks++; if (txe !== 1'b1) begin failures++; $display("FAIL rst_txe got=%b exp=1", txe); end
        checks++; if ({shift_out, tx_start, tx_busy, tx_crc_phase, tx_done, underrun} !== 6'b0) begin
            failures++; $display("FAIL rst_flags got=%b exp=000000",
                                 {shift_out, tx_start, tx_busy, tx_crc_phase, tx_done, underrun});
        end
        checks++; if (crc_out !== 32'h0) begin failures++; $display("FAIL rst_crc got=%h exp=0", crc_out); end
        spi_tx_rst = 1'b0;
        step();
    endtask

    task automatic test_msb_single();
        set_cfg(7, 1'b0, 1'b0, 0, 32'h0);
        exp_word(32'hA5, 7, 1'b0);
        fork
            push_word(32'hA5);
            collect(40);
        join
        checks++; if (!done_seen || done_cyc != 10) begin failures++; $display("FAIL msb_done got=%0d exp=10", done_cyc); end
        checks++; if (start_cyc.size() != 1 || start_cyc[0] != 1) begin failures++; $display("FAIL msb_start got=%0d exp=1 start", start_cyc.size()); end
        checks++; if (first_busy != 2) begin failures++; $display("FAIL msb_latency got=%0d exp=2", first_busy); end
        checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL msb_len got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && exp_q.size() > 0; i++) begin
            bit e = exp_q.pop_front();
            checks++; if (obs_q[i] !== e) begin failures++; $display("FAIL msb_bit[%0d] got=%b exp=%b", i, obs_q[i], e); end
        end
        checks++; if (txe !== 1'b1) begin failures++; $display("FAIL msb_txe got=%b exp=1", txe); end
        exp_q.delete();
        step();
    endtask

    task automatic test_back_to_back();
        set_cfg(15, 1'b1, 1'b0, 0, 32'h0);
        exp_word(32'h1234, 15, 1'b1);
        exp_word(32'hABCD, 15, 1'b1);
        fork
            begin
                push_word(32'h1234);
                push_word(32'hABCD);
            end
            collect(60);
        join
        checks++; if (!done_seen) begin failures++; $display("FAIL b2b_done got=0 exp=1"); end
        checks++; if (start_cyc.size() != 2 || start_cyc[1] - start_cyc[0] != 16) begin
            failures++; $display("FAIL b2b_starts got=%0d pulses exp=2 pulses 16 apart", start_cyc.size());
        end
        checks++; if (last_busy - first_busy + 1 != 32 || obs_q.size() != 32) begin
            failures++; $display("FAIL b2b_gap got=%0d bits exp=32 contiguous", obs_q.size());
        end
        for (int i = 0; i < obs_q.size() && exp_q.size() > 0; i++) begin
            bit e = exp_q.pop_front();
            checks++; if (obs_q[i] !== e) begin failures++; $display("FAIL b2b_bit[%0d] got=%b exp=%b", i, obs_q[i], e); end
        end
        exp_q.delete();
        step();
    endtask

    task automatic test_crc();
        logic [31:0] crc_m;
        set_cfg(7, 1'b0, 1'b1, 2, 32'h07);
        exp_word(32'h01, 7, 1'b0);
        exp_word(32'h02, 7, 1'b0);
        crc_m = model_crc(7, 32'h07);
        exp_word(crc_m, 7, 1'b0);
        fork
            begin
                push_word(32'h01);
                push_word(32'h02);
            end
            collect(60);
        join
        checks++; if (!done_seen) begin failures++; $display("FAIL crc_done got=0 exp=1"); end
        checks++; if (n_crc != 8) begin failures++; $display("FAIL crc_phase got=%0d exp=8", n_crc); end
        checks++; if (crc_out !== 32'h1B) begin failures++; $display("FAIL crc_out got=%h exp=0000001b", crc_out); end
        checks++; if (obs_q.size() != 24) begin failures++; $display("FAIL crc_len got=%0d exp=24", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && exp_q.size() > 0; i++) begin
            bit e = exp_q.pop_front();
            checks++; if (obs_q[i] !== e) begin failures++; $display("FAIL crc_bit[%0d] got=%b exp=%b", i, obs_q[i], e); end
        end
        exp_q.delete();
        step();
    endtask

    task automatic test_underrun();
        set_cfg(7, 1'b0, 1'b0, 3, 32'h0);
        exp_word(32'hC3, 7, 1'b0);
        exp_word(32'h00, 7, 1'b0);
        exp_word(32'h00, 7, 1'b0);
        fork
            push_word(32'hC3);
            collect(60);
        join
        checks++; if (!done_seen) begin failures++; $display("FAIL und_done got=0 exp=1"); end
        checks++; if (n_under != 2) begin failures++; $display("FAIL und_pulses got=%0d exp=2", n_under); end
        checks++; if (obs_q.size() != 24) begin failures++; $display("FAIL und_len got=%0d exp=24", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && exp_q.size() > 0; i++) begin
            bit e = exp_q.pop_front();
            checks++; if (obs_q[i] !== e) begin failures++; $display("FAIL und_bit[%0d] got=%b exp=%b", i, obs_q[i], e); end
        end
        exp_q.delete();
        step();
    endtask

    task automatic test_fifo_full();
        logic [31:0] w;
        set_cfg(7, 1'b0, 1'b0, 0, 32'h0);
        rxonly = 1'b1;
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            w = 32'h10 + 32'(i) * 32'h11;
            if (i < 4) exp_word(w, 7, 1'b0);
            push_word(w);
            checks++; if (wr_ready !== (i < 3)) begin
                failures++; $display("FAIL full_ready[%0d] got=%b exp=%b", i, wr_ready, (i < 3));
            end
        end
        rxonly = 1'b0;
        collect(80);
        checks++; if (!done_seen) begin failures++; $display("FAIL full_done got=0 exp=1"); end
        checks++; if (start_cyc.size() != 4) begin failures++; $display("FAIL full_frames got=%0d exp=4", start_cyc.size()); end
        checks++; if (obs_q.size() != 32) begin failures++; $display("FAIL full_len got=%0d exp=32", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && exp_q.size() > 0; i++) begin
            bit e = exp_q.pop_front();
            checks++; if (obs_q[i] !== e) begin failures++; $display("FAIL full_bit[%0d] got=%b exp=%b", i, obs_q[i], e); end
        end
        exp_q.delete();
        step();
    endtask

    task automatic test_abort();
        int n_done;
        set_cfg(7, 1'b0, 1'b0, 0, 32'h0);
        fork
            begin
                push_word(32'hFF);
                push_word(32'h81);
            end
            collect(5);
        join
        checks++; if (tx_busy !== 1'b1) begin failures++; $display("FAIL abort_pre_busy got=%b exp=1", tx_busy); end
        rxonly = 1'b1;
        step();
        checks++; if (tx_busy !== 1'b0 || shift_out !== 1'b0) begin
            failures++; $display("FAIL abort_idle got=busy %b line %b exp=0 0", tx_busy, shift_out);
        end
        checks++; if (txe !== 1'b1) begin failures++; $display("FAIL abort_txe got=%b exp=1", txe); end
        n_done = 0;
        for (int c = 0; c < 12; c++) begin
            if (tx_done) n_done++;
            step();
        end
        checks++; if (n_done != 0) begin failures++; $display("FAIL abort_done got=%0d exp=0", n_done); end
        rxonly = 1'b0;
        step();
        push_word(32'hFF);
        step();
        step();
        step();
        checks++; if (tx_busy !== 1'b1) begin failures++; $display("FAIL rst_pre_busy got=%b exp=1", tx_busy); end
        spi_tx_rst = 1'b1;
        step();
        checks++; if ({wr_ready, txe} !== 2'b11) begin failures++; $display("FAIL midrst_ready_txe got=%b exp=11", {wr_ready, txe}); end
        checks++; if ({shift_out, tx_start, tx_busy, tx_crc_phase, tx_done, underrun} !== 6'b0) begin
            failures++; $display("FAIL midrst_flags got=%b exp=000000",
                                 {shift_out, tx_start, tx_busy, tx_crc_phase, tx_done, underrun});
        end
        checks++; if (crc_out !== 32'h0) begin failures++; $display("FAIL midrst_crc got=%h exp=0", crc_out); end
        spi_tx_rst = 1'b0;
        step();
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        spi_tx_rst = 1'b1;
        wr_data    = '0;
        wr_valid   = 1'b0;
        rxonly     = 1'b0;
        set_cfg(7, 1'b0, 1'b0, 0, 32'h0);
        test_reset();
        test_msb_single();
        test_back_to_back();
        test_crc();
        test_underrun();
        test_fifo_full();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_txc_stream.md
# spi_txc_stream

Parametrised next-generation SPI transmit shifter sitting between the register/DMA write port and the MOSI/MISO pad driver. It buffers words in a small FIFO, serialises frames of any length from 4 to DW bits MSB- or LSB-first back-to-back, and counts frames per transaction. At the end of a fixed-length transaction it optionally appends a serial CRC frame, and it flags underrun.

## Interface
Parameters:
- DW, 32: maximum frame width in bits (≥4).
- DEPTH, 4: TX FIFO depth in words (power of two, ≥2).
- CW, 13: frame-counter width.

Ports:
- sclk_tx  in  1  shift clock; all logic on its rising edge.
- spi_tx_rst  in  1  reset, synchronous, active-high.
- wr_data  in  DW  word to transmit; bits above frame_len ignored.
- wr_valid  in  1  push request.
- wr_ready  out  1  FIFO not full.
- frame_len  in  $clog2(DW)  frame bits minus 1 (3..DW-1).
- lsbf  in  1  1 = bit 0 first; 0 = bit frame_len first.
- crc_en  in  1  append CRC frame after last data frame.
- crc_poly  in  DW  polynomial; low frame_len+1 bits used.
- tnum_max  in  CW  frames per transaction; 0 = streaming mode.
- rxonly  in  1  abort and hold transmitter idle.
- shift_out  out  1  serial data to the pad.
- txe  out  1  FIFO empty.
- tx_start  out  1  one-cycle pulse per word popped.
- tx_busy  out  1  state ≠ IDLE.
- tx_crc_phase  out  1  CRC frame on the line.
- tx_done  out  1  one-cycle pulse at the end of a transaction.
- underrun  out  1  one-cycle pulse when a zero frame is substituted.
- crc_out  out  DW  running CRC, zero-extended.

## Operation
- FIFO: push when wr_valid & wr_ready. wr_ready = !full, based on the registered count only, so a push is rejected while full even if a pop occurs in the same cycle.
- Configuration (frame_len, lsbf, crc_en, tnum_max, crc_poly) is captured into shadow registers on IDLE→SHIFT. Changes during a transaction have no effect.
- States:
  - IDLE: shift_out = 0. If !rxonly & !txe: pop, load the sorted word, clear bit_cnt/frame_cnt/CRC, pulse tx_start, go to SHIFT.
  - SHIFT: shift one bit per cycle; bit_cnt++. On the cycle the last bit is on the line (bit_cnt == frame_len), frame_cnt++, then:
    - (a) tnum_max ≠ 0 and frame_cnt+1 == tnum_max: if crc_en, load the sorted CRC and go to CRC; else go to IDLE and pulse tx_done.
    - (b) FIFO non-empty: pop, load, pulse tx_start, stay in SHIFT with no gap bit.
    - (c) FIFO empty in streaming mode: go to IDLE and pulse tx_done.
    - (d) FIFO empty with tnum_max ≠ 0: load all-zero, pulse underrun, stay in SHIFT. The zero frame counts toward tnum_max.
  - CRC: shift frame_len+1 CRC bits in the same bit order as data. On the last bit go to IDLE and pulse tx_done.
- CRC is computed over every bit driven in SHIFT, including zero-fill frames:
  - width W = frame_len+1, init 0, no reflection;
  - per bit b: crc = ((crc<<1) ^ (poly & {W{crc[W-1]^b}})) masked to W bits.
  - crc_out is frozen during CRC and holds until the next transaction start.
- rxonly = 1 in any state: next cycle the block is in IDLE, the FIFO is flushed, shift_out = 0, and no tx_done is issued.

## Timing
- Reset values: wr_ready = 1, txe = 1; all other outputs 0. The FIFO is emptied.
- Latency: a push at edge k into an empty FIFO in IDLE puts the first bit on shift_out after edge k+1; tx_start is high in cycle k+1.
- Frame period is exactly frame_len+1 cycles. Consecutive frames and the CRC frame are contiguous.
- tx_done is asserted in the cycle after the last bit, with state = IDLE in that cycle. A new transaction can start in that same cycle (IDLE pop).
- frame_cnt saturates at tnum_max. In streaming mode it wraps modulo 2^CW.

## Structure
- Package spi_tx_pkg holds:
  - the state enum (IDLE, SHIFT, CRC);
  - the frame-length-to-width helper;
  - the bit-order sort function (lsbf/frame_len, reversing bits 0..frame_len only).
- Sub-module spi_serial_crc: width-selectable serial Galois CRC with init/enable inputs.
- The FIFO stays inline as a register array with pointers.

## Test plan
- DW=32, frame_len=7, lsbf=0, tnum_max=0, push 8'hA5: shift_out = 1,0,1,0,0,1,0,1 starting one cycle after the push; then tx_done; txe = 1.
- frame_len=15, lsbf=1, push 16'h1234 and 16'hABCD back-to-back: 32 contiguous bits LSB-first with no gap; two tx_start pulses 16 cycles apart.
- frame_len=7, tnum_max=2, crc_en=1, poly=8'h07, data 8'h01 then 8'h02: a third frame carries CRC 8'h1B MSB-first (check against a software model); tx_crc_phase is high for 8 cycles; tx_done follows.
- tnum_max=3, push one word only: frames 2 and 3 are all-zero; underrun pulses twice; tx_done after 24 bits.
- DEPTH=4, push 5 words while IDLE with rxonly=1: wr_ready = 0 after the 4th push and the 5th is dropped; deassert rxonly → exactly 4 frames are sent.
- Assert rxonly mid-frame, then spi_tx_rst mid-frame: IDLE, shift_out = 0, txe = 1, no tx_done, all outputs at reset values.
